// File: rtl/game_state_pkg.sv
// Shared types and constants for the game_state block.
// Mode, result and state encodings plus the tally limit.
package game_state_pkg;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_e;

  localparam int TALLY_W = 4;
  localparam logic [TALLY_W-1:0] TALLY_MAX = 4'd15;

endpackage

// File: rtl/game_tally_counter.sv
// 4-bit hit tally with sync clear and increment enable.
// reached_max_o flags that the value after this edge is TALLY_MAX.
module game_tally_counter
  import game_state_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic reached_max_o
);

  logic [TALLY_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign reached_max_o = (count_d == TALLY_MAX);

endmodule

// File: rtl/game_state.sv
// Multi-mode game counter with win/loss tallies.
// Game ends when either tally reaches TALLY_MAX.
module game_state
  import game_state_pkg::*;
#(
  parameter int COUNTER_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              control,
  input  logic [COUNTER_SIZE-1:0] i_value,
  input  logic                    INIT,
  output logic [1:0]              who,
  output logic                    los,
  output logic                    win,
  output logic                    gameover
);

  state_e state_q, state_d;
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d, step;
  logic [1:0] who_q, who_d;
  logic run, tally_en, down;
  logic win_max, los_max;
  mode_e mode;

  assign mode = mode_e'(control);
  assign down = (mode == DN1) || (mode == DN2);
  assign step = ((mode == UP2) || (mode == DN2)) ?
                COUNTER_SIZE'(2) : COUNTER_SIZE'(1);

  assign run      = (state_q == RUN);
  assign win      = run & (&cnt_q);
  assign los      = run & ~(|cnt_q);
  assign gameover = (state_q == OVER);
  assign who      = who_q;
  assign tally_en = run & ~INIT;

  game_tally_counter u_win_tally (
    .clk           (clk),
    .rst_n         (reset),
    .clr_i         (INIT),
    .inc_i         (tally_en & win),
    .reached_max_o (win_max)
  );

  game_tally_counter u_los_tally (
    .clk           (clk),
    .rst_n         (reset),
    .clr_i         (INIT),
    .inc_i         (tally_en & los),
    .reached_max_o (los_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    who_d   = who_q;
    if (INIT) begin
      cnt_d   = i_value;
      who_d   = WHO_NONE;
      state_d = RUN;
    end else if (run) begin
      cnt_d = down ? cnt_q - step : cnt_q + step;
      // Only one tally can move per edge, so win has no real priority.
      if (win_max) begin
        state_d = OVER;
        who_d   = WHO_WINNER;
      end else if (los_max) begin
        state_d = OVER;
        who_d   = WHO_LOSER;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      who_q   <= WHO_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      who_q   <= who_d;
    end
  end

endmodule

// File: tb/tb_game_state.sv
// Randomized bench for game_state against an integer model.
// Directed games, async reset and random control/INIT/reset.
module tb_game_state;

  logic       clk;
  logic       reset;
  logic [1:0] control;
  logic [3:0] i_value;
  logic       INIT;
  logic [1:0] who;
  logic       los;
  logic       win;
  logic       gameover;

  int n_checks;
  int n_fail;

  // model: st 0=idle 1=run 2=over
  int m_st, m_cnt, m_wt, m_lt, m_who;

  game_state #(.COUNTER_SIZE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .control  (control),
    .i_value  (i_value),
    .INIT     (INIT),
    .who      (who),
    .los      (los),
    .win      (win),
    .gameover (gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_wt = 0;
    m_lt = 0; m_who = 0;
  endfunction

  function automatic void model_edge(input int c,
                                     input int v,
                                     input bit init);
    int d;
    if (init) begin
      m_cnt = v; m_wt = 0; m_lt = 0;
      m_who = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (m_cnt == 15) m_wt++;
      if (m_cnt == 0)  m_lt++;
      d = (c % 2) + 1;
      if (c >= 2) d = -d;
      m_cnt = ((m_cnt + d) % 16 + 16) % 16;
      if (m_wt == 15) begin
        m_st = 2; m_who = 2;
      end else if (m_lt == 15) begin
        m_st = 2; m_who = 1;
      end
    end
  endfunction

  task automatic compare_all(input string pfx);
    check({pfx, "_who"}, int'(who), m_who);
    check({pfx, "_win"}, int'(win),
          int'(m_st == 1 && m_cnt == 15));
    check({pfx, "_los"}, int'(los),
          int'(m_st == 1 && m_cnt == 0));
    check({pfx, "_gameover"}, int'(gameover),
          int'(m_st == 2));
  endtask

  task automatic cycle(input logic [1:0] c,
                       input logic [3:0] v,
                       input logic init);
    control = c; i_value = v; INIT = init;
    @(posedge clk);
    model_edge(int'(c), int'(v), init);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all("rst");
    @(posedge clk);
    @(negedge clk);
    compare_all("rst_hold");
    reset = 1'b1;
  endtask

  task automatic scenario(input logic [1:0] c,
                          input logic [3:0] v,
                          input int exp_n,
                          input int exp_who);
    int n;
    cycle(c, v, 1'b1);
    n = 0;
    while (!gameover && n < 400) begin
      cycle(c, v, 1'b0);
      n++;
    end
    check("over_cycles", n, exp_n);
    check("over_who", int'(who), exp_who);
    repeat (4) cycle(2'(n), 4'(n), 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    control = 2'b00;
    i_value = 4'd0;
    INIT = 1'b0;
    reset = 1'b0;
    model_reset();
    #12;
    compare_all("por");
    @(negedge clk);
    reset = 1'b1;

    repeat (5) cycle(2'($urandom), 4'($urandom), 1'b0);

    scenario(2'b00, 4'd0,  225, 1);
    scenario(2'b00, 4'd15, 225, 2);
    scenario(2'b10, 4'd0,  225, 1);
    scenario(2'b10, 4'd15, 225, 2);
    scenario(2'b01, 4'd0,  113, 1);
    scenario(2'b11, 4'd1,  114, 2);

    cycle(2'b00, 4'd7, 1'b1);
    repeat (20) cycle(2'b00, 4'd0, 1'b0);
    async_reset();
    repeat (6) cycle(2'($urandom), 4'($urandom), 1'b0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cycle(2'($urandom), 4'($urandom),
              1'($urandom_range(0, 149) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
